// File: rtl/forth_bus_pkg.sv
// Shared definitions for the Forth CPU bus responder: address map,
// register bit positions, FSM encoding and interrupt-acknowledge decoding.
package forth_bus_pkg;

    // Peripheral register addresses (compared against the full bus width).
    localparam int unsigned ADDR_TIMER_LOAD  = 32'h0000_FF00;
    localparam int unsigned ADDR_TIMER_COUNT = 32'h0000_FF01;
    localparam int unsigned ADDR_CTRL        = 32'h0000_FF02;
    localparam int unsigned ADDR_STATUS      = 32'h0000_FF03;
    localparam int unsigned ADDR_SOFT_IRQ    = 32'h0000_FF04;

    // CTRL register layout.
    localparam int CTRL_W           = 4;
    localparam int CTRL_TIMER_EN    = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ0_EN     = 2;
    localparam int CTRL_IRQ1_EN     = 3;

    // STATUS register layout; the two pend bits share their index with the
    // in_service bit of the interrupt line they drive.
    localparam int STATUS_W         = 3;
    localparam int STAT_TIMER_PEND  = 0;
    localparam int STAT_SOFT_PEND   = 1;
    localparam int STAT_BUS_FAULT   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } bus_state_t;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_RAM,
        REG_TIMER_LOAD,
        REG_TIMER_COUNT,
        REG_CTRL,
        REG_STATUS,
        REG_SOFT_IRQ
    } reg_sel_t;

    typedef enum logic [1:0] {
        ACK_NONE  = 2'd0,
        ACK_LINE0 = 2'd1,
        ACK_LINE1 = 2'd2
    } irq_ack_t;

    // Encoded acknowledge value -> one-hot in_service set mask.
    function automatic logic [1:0] ack_to_mask(input logic [1:0] ack);
        case (ack)
            ACK_LINE0: return 2'b01;
            ACK_LINE1: return 2'b10;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/forth_bus_responder_if.sv
// Forth CPU memory port: valid/nwr/ready handshake plus the 2-line IRQ pair.
interface forth_bus_responder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] bus_address;
    logic [WIDTH-1:0] bus_wdata;
    logic             bus_valid;
    logic             bus_nwr;
    logic [WIDTH-1:0] bus_rdata;
    logic             bus_ready;
    logic [1:0]       irq;
    logic [1:0]       irq_ack;

    modport master (
        output bus_address, bus_wdata, bus_valid, bus_nwr, irq_ack,
        input  bus_rdata, bus_ready, irq
    );

    modport slave (
        input  bus_address, bus_wdata, bus_valid, bus_nwr, irq_ack,
        output bus_rdata, bus_ready, irq
    );
endinterface

// File: rtl/forth_timer.sv
// Down-counting peripheral timer. expire is high for every enabled cycle in
// which the count sits at zero; the owner decides whether that disables it.
module forth_timer #(
    parameter int TIMER_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  auto_reload,
    input  logic                  load_we,
    input  logic [TIMER_BITS-1:0] load_val,
    output logic [TIMER_BITS-1:0] load_q,
    output logic [TIMER_BITS-1:0] count_q,
    output logic                  expire
);

    assign expire = en && (count_q == '0);

    // Reload register and counter; a CPU load overrides a same-cycle reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_q  <= '0;
            count_q <= '0;
        end else if (load_we) begin
            load_q  <= load_val;
            count_q <= load_val;
        end else if (en) begin
            if (count_q == '0) begin
                if (auto_reload) begin
                    count_q <= load_q;
                end
            end else begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/forth_bus_responder.sv
// Responder on the Forth CPU data bus: RAM, timer/IRQ register block and
// the registered 2-line interrupt request.
//
// state  | meaning
// S_IDLE | no access; sample bus_valid and latch the request
// S_WAIT | wait states counting down
// S_RESP | bus_ready high, read data presented, write commits at end
// S_HOLD | access done; wait for the CPU to drop bus_valid
module forth_bus_responder
    import forth_bus_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int RAM_BITS    = 8,
    parameter int WAIT_STATES = 1,
    parameter int TIMER_BITS  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    forth_bus_responder_if.slave   bus
);

    bus_state_t         state_q, state_d;
    logic [2:0]         wait_cnt_q, wait_cnt_d;
    logic               latch;
    logic [WIDTH-1:0]   addr_q, wdata_q;
    logic               nwr_q;
    logic [WIDTH-1:0]   ram_mem [0:(1<<RAM_BITS)-1];
    logic [WIDTH-1:0]   rdata_q, rd_data;
    logic [WIDTH-1:0]   addr_mux;
    logic               nwr_mux;
    reg_sel_t           rd_sel, wr_sel;
    logic               wr_en, acc_fault, soft_set;

    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [STATUS_W-1:0] status_q, status_d, w1c, hw_set;
    logic [1:0]          in_service_q, in_service_d, ack_q, ack_mask, irq_q, irq_d;

    logic [TIMER_BITS-1:0] tmr_load, tmr_count;
    logic                  tmr_expire, tmr_load_we;

    function automatic reg_sel_t decode_addr(input logic [WIDTH-1:0] a);
        if ((a >> RAM_BITS) == '0)             return REG_RAM;
        if (a == WIDTH'(ADDR_TIMER_LOAD))      return REG_TIMER_LOAD;
        if (a == WIDTH'(ADDR_TIMER_COUNT))     return REG_TIMER_COUNT;
        if (a == WIDTH'(ADDR_CTRL))            return REG_CTRL;
        if (a == WIDTH'(ADDR_STATUS))          return REG_STATUS;
        if (a == WIDTH'(ADDR_SOFT_IRQ))        return REG_SOFT_IRQ;
        return REG_NONE;
    endfunction

    // Next-state logic for the bus handshake.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        latch      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.bus_valid) begin
                    latch      = 1'b1;
                    wait_cnt_d = 3'(WAIT_STATES);
                    state_d    = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 3'd1;
                if (wait_cnt_q <= 3'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_HOLD;
            S_HOLD: begin
                if (!bus.bus_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and request latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            nwr_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (latch) begin
                addr_q  <= bus.bus_address;
                wdata_q <= bus.bus_wdata;
                nwr_q   <= bus.bus_nwr;
            end
        end
    end

    // With no wait states the read data must be fetched in the sampling
    // cycle itself, so the read path looks at the live bus while idle.
    assign addr_mux = (state_q == S_IDLE) ? bus.bus_address : addr_q;
    assign nwr_mux  = (state_q == S_IDLE) ? bus.bus_nwr     : nwr_q;
    assign rd_sel   = decode_addr(addr_mux);
    assign wr_sel   = decode_addr(addr_q);

    // Read data mux; unused upper bits read as zero.
    always_comb begin
        rd_data = '0;
        case (rd_sel)
            REG_RAM:         rd_data = ram_mem[addr_mux[RAM_BITS-1:0]];
            REG_TIMER_LOAD:  rd_data = WIDTH'(tmr_load);
            REG_TIMER_COUNT: rd_data = WIDTH'(tmr_count);
            REG_CTRL:        rd_data = WIDTH'(ctrl_q);
            REG_STATUS:      rd_data = WIDTH'(status_q);
            default:         rd_data = '0;
        endcase
    end

    // Registered read data, valid only during the ready cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= (state_d == S_RESP && nwr_mux) ? rd_data : '0;
        end
    end

    assign wr_en     = (state_q == S_RESP) && !nwr_q;
    assign acc_fault = (state_q == S_RESP) && (wr_sel == REG_NONE);
    assign soft_set  = wr_en && (wr_sel == REG_SOFT_IRQ) && wdata_q[0];

    // RAM write at the closing edge of the response cycle.
    always_ff @(posedge clk) begin
        if (!reset && wr_en && wr_sel == REG_RAM) begin
            ram_mem[addr_q[RAM_BITS-1:0]] <= wdata_q;
        end
    end

    assign tmr_load_we = wr_en && (wr_sel == REG_TIMER_LOAD);

    forth_timer #(
        .TIMER_BITS (TIMER_BITS)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .en          (ctrl_q[CTRL_TIMER_EN]),
        .auto_reload (ctrl_q[CTRL_AUTO_RELOAD]),
        .load_we     (tmr_load_we),
        .load_val    (wdata_q[TIMER_BITS-1:0]),
        .load_q      (tmr_load),
        .count_q     (tmr_count),
        .expire      (tmr_expire)
    );

    // Register-block next values: hardware sets beat W1C, W1C beats ack.
    always_comb begin
        ctrl_d = ctrl_q;
        if (tmr_expire && !ctrl_q[CTRL_AUTO_RELOAD]) begin
            ctrl_d[CTRL_TIMER_EN] = 1'b0;
        end
        if (wr_en && wr_sel == REG_CTRL) begin
            ctrl_d = wdata_q[CTRL_W-1:0];
        end

        w1c = (wr_en && wr_sel == REG_STATUS) ? wdata_q[STATUS_W-1:0] : '0;
        hw_set = '0;
        hw_set[STAT_TIMER_PEND] = tmr_expire;
        hw_set[STAT_SOFT_PEND]  = soft_set;
        hw_set[STAT_BUS_FAULT]  = acc_fault;
        status_d = (status_q & ~w1c) | hw_set;

        ack_mask     = (bus.irq_ack != ack_q) ? ack_to_mask(bus.irq_ack) : 2'b00;
        in_service_d = (in_service_q | ack_mask) & ~w1c[1:0];

        irq_d[0] = status_d[STAT_TIMER_PEND] & ctrl_d[CTRL_IRQ0_EN] & ~in_service_d[0];
        irq_d[1] = status_d[STAT_SOFT_PEND]  & ctrl_d[CTRL_IRQ1_EN] & ~in_service_d[1];
    end

    // Register block, ack edge tracking and registered IRQ outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q       <= '0;
            status_q     <= '0;
            in_service_q <= '0;
            ack_q        <= '0;
            irq_q        <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            status_q     <= status_d;
            in_service_q <= in_service_d;
            ack_q        <= bus.irq_ack;
            irq_q        <= irq_d;
        end
    end

    assign bus.bus_ready = (state_q == S_RESP);
    assign bus.bus_rdata = rdata_q;
    assign bus.irq       = irq_q;

endmodule

// File: tb/tb_forth_bus_responder.sv
// Bench for forth_bus_responder: directed bus accesses with a response
// scoreboard, plus cycle-timed interrupt checks.
module tb_forth_bus_responder;

    localparam int WIDTH = 16;
    localparam int WS    = 1;

    typedef struct {
        bit          is_read;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    forth_bus_responder_if #(.WIDTH(WIDTH)) bus ();

    forth_bus_responder #(
        .WIDTH       (WIDTH),
        .RAM_BITS    (8),
        .WAIT_STATES (WS),
        .TIMER_BITS  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse consumes one expected response.
    always @(negedge clk) begin
        if (bus.bus_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no pending access");
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_read) begin
                    chk($sformatf("rdata@%h", mon_e.addr), 32'(bus.bus_rdata), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic access(input bit nwr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp, input int hold_extra);
        int lat;
        @(negedge clk);
        bus.bus_valid   = 1'b1;
        bus.bus_nwr     = nwr;
        bus.bus_address = addr;
        bus.bus_wdata   = wdata;
        exp_q.push_back('{is_read: nwr, addr: addr, data: exp});
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.bus_ready !== 1'b1 && lat < 20);
        chk($sformatf("latency@%h", addr), 32'(lat), 32'(WS + 1));
        repeat (hold_extra) @(negedge clk);
        bus.bus_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        access(1'b0, addr, data, 16'h0000, 0);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp);
        access(1'b1, addr, 16'h0000, exp, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        reset           = 1'b1;
        bus.bus_valid   = 1'b0;
        bus.bus_nwr     = 1'b1;
        bus.bus_address = '0;
        bus.bus_wdata   = '0;
        bus.irq_ack     = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus.bus_ready), 32'h0);
        chk("reset_rdata", 32'(bus.bus_rdata), 32'h0);
        chk("reset_irq",   32'(bus.irq),       32'h0);
        reset = 1'b0;
        @(negedge clk);

        // 1: RAM write/read, valid held past ready
        wr(16'h0010, 16'h1234);
        access(1'b1, 16'h0010, 16'h0000, 16'h1234, 3);
        wr(16'h00FF, 16'hA5A5);
        rd(16'h00FF, 16'hA5A5);

        // 2: unmapped accesses and bus_fault W1C
        rd(16'h8000, 16'h0000);
        rd(16'hFF03, 16'h0004);
        wr(16'hFF03, 16'h0004);
        rd(16'hFF03, 16'h0000);
        rd(16'hFF04, 16'h0000);
        rd(16'hFF03, 16'h0000);
        wr(16'h0100, 16'h1111);
        rd(16'h0100, 16'h0000);
        rd(16'hFF03, 16'h0004);
        wr(16'hFF03, 16'h0004);

        // 3: timer IRQ timing, ack masking, re-assertion
        wr(16'hFF00, 16'h0003);
        rd(16'hFF01, 16'h0003);
        wr(16'hFF02, 16'h0007);
        repeat (3) @(negedge clk);
        chk("irq_before_expiry", 32'(bus.irq), 32'h0);
        @(negedge clk);
        chk("irq0_on_expiry", 32'(bus.irq), 32'h1);
        bus.irq_ack = 2'd1;
        @(negedge clk);
        chk("irq0_acked", 32'(bus.irq), 32'h0);
        wr(16'hFF03, 16'h0001);
        chk("irq_after_w1c", 32'(bus.irq), 32'h0);
        bus.irq_ack = 2'd0;
        waited = 0;
        while (bus.irq !== 2'b01 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        chk("irq0_reasserts", 32'(bus.irq), 32'h1);

        // 4: soft IRQ on line 1, ack of line 1 only
        wr(16'hFF02, 16'h000F);
        wr(16'hFF04, 16'h0001);
        chk("irq_both", 32'(bus.irq), 32'h3);
        bus.irq_ack = 2'd2;
        @(negedge clk);
        chk("irq1_acked", 32'(bus.irq), 32'h1);
        bus.irq_ack = 2'd0;
        @(negedge clk);
        chk("irq_after_ack_release", 32'(bus.irq), 32'h1);
        wr(16'hFF02, 16'h0000);
        wr(16'hFF03, 16'h0007);
        rd(16'hFF03, 16'h0000);
        chk("irq_cleared", 32'(bus.irq), 32'h0);

        // 5: one-shot expiry lands on the W1C commit edge
        wr(16'hFF00, 16'h0003);
        wr(16'hFF02, 16'h0001);
        wr(16'hFF03, 16'h0001);
        rd(16'hFF03, 16'h0001);
        rd(16'hFF02, 16'h0000);
        rd(16'hFF01, 16'h0000);
        rd(16'hFF00, 16'h0003);
        wr(16'hFF03, 16'h0001);

        // 6: reset during the wait state of a write
        wr(16'h0020, 16'h5555);
        wr(16'hFF00, 16'h0000);
        wr(16'hFF02, 16'h0007);
        repeat (2) @(negedge clk);
        chk("irq_before_reset", 32'(bus.irq), 32'h1);
        @(negedge clk);
        bus.bus_valid   = 1'b1;
        bus.bus_nwr     = 1'b0;
        bus.bus_address = 16'h0020;
        bus.bus_wdata   = 16'hBEEF;
        @(negedge clk);
        reset         = 1'b1;
        bus.bus_valid = 1'b0;
        bus.bus_nwr   = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_ready", 32'(bus.bus_ready), 32'h0);
        chk("abort_rdata", 32'(bus.bus_rdata), 32'h0);
        chk("abort_irq",   32'(bus.irq),       32'h0);
        reset = 1'b0;
        @(negedge clk);
        rd(16'h0020, 16'h5555);
        rd(16'hFF00, 16'h0000);
        rd(16'hFF02, 16'h0000);
        rd(16'hFF03, 16'h0000);
        rd(16'h0010, 16'h1234);

        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
